// File: rtl/control_fsm.sv
// ============================================================================
// Module   : control_fsm
// Purpose  : Multicycle controller that sequences fetch/decode/execute and
//            drives the datapath mux selects and enables (includes LM/SM loop).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module control_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       compare,
    output logic [2:0] Mux1_alu_B,
    output logic [2:0] Mux2_alu_A,
    output logic [1:0] Mux3_RF_wen,
    output logic [2:0] Mux4_RF_wadd,
    output logic [1:0] Mux5_RF_read2,
    output logic       Mux6_RF_dataIn,
    output logic [1:0] Mux8_memwrite,
    output logic       Mux9_memDataIn,
    output logic       CZen,
    output logic       ALU_op,
    output logic       memRead,
    output logic       wIR,
    output logic       wtmpA,
    output logic [2:0] counter,
    output logic [3:0] state
);

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_ADI = 4'b0001;
    localparam logic [3:0] c_OP_NDU = 4'b0010;
    localparam logic [3:0] c_OP_LHI = 4'b0011;
    localparam logic [3:0] c_OP_LW  = 4'b0100;
    localparam logic [3:0] c_OP_SW  = 4'b0101;
    localparam logic [3:0] c_OP_LM  = 4'b0110;
    localparam logic [3:0] c_OP_SM  = 4'b0111;
    localparam logic [3:0] c_OP_JAL = 4'b1000;
    localparam logic [3:0] c_OP_JLR = 4'b1001;
    localparam logic [3:0] c_OP_BEQ = 4'b1100;

    typedef enum logic [3:0] {
        S_FETCH0 = 4'd0,
        S_FETCH1 = 4'd1,
        S_DECODE = 4'd2,
        S_ALU    = 4'd3,
        S_WB     = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM    = 4'd6,
        S_LMA    = 4'd7,
        S_LMM    = 4'd8,
        S_CMP    = 4'd9,
        S_BR     = 4'd10,
        S_LINK   = 4'd11,
        S_LWR    = 4'd12,
        S_JR     = 4'd13,
        S_PCINC  = 4'd14,
        S_PCWR   = 4'd15
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_counter;
    logic [2:0] w_counter_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= state_t'(RESET_STATE);
            r_counter <= 3'd0;
        end else begin
            r_state   <= w_next;
            r_counter <= w_counter_nxt;
        end
    end

    assign state   = r_state;
    assign counter = r_counter;

    always_comb begin
        w_next         = S_FETCH0;
        w_counter_nxt  = r_counter;
        Mux1_alu_B     = 3'd0;
        Mux2_alu_A     = 3'd0;
        Mux3_RF_wen    = 2'd0;
        Mux4_RF_wadd   = 3'd0;
        Mux5_RF_read2  = 2'd0;
        Mux6_RF_dataIn = 1'b0;
        Mux8_memwrite  = 2'd0;
        Mux9_memDataIn = 1'b0;
        CZen           = 1'b0;
        ALU_op         = 1'b0;
        memRead        = 1'b0;
        wIR            = 1'b0;
        wtmpA          = 1'b0;

        case (r_state)
            S_FETCH0: begin
                Mux5_RF_read2 = 2'd2;
                Mux2_alu_A    = 3'd0;
                Mux1_alu_B    = 3'd2;
                w_next        = S_FETCH1;
            end
            S_FETCH1: begin
                memRead = 1'b1;
                wIR     = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                wtmpA         = 1'b1;
                Mux5_RF_read2 = 2'd0;
                w_counter_nxt = 3'd0;
                case (opcode)
                    c_OP_ADD, c_OP_NDU, c_OP_ADI, c_OP_LHI: w_next = S_ALU;
                    c_OP_LW, c_OP_SW:                       w_next = S_ADDR;
                    c_OP_LM, c_OP_SM:                       w_next = S_LMA;
                    c_OP_JAL, c_OP_JLR:                     w_next = S_LINK;
                    c_OP_BEQ:                               w_next = S_CMP;
                    default:                                w_next = S_PCINC;
                endcase
            end
            S_ALU: begin
                case (opcode)
                    c_OP_ADD: begin
                        Mux2_alu_A = 3'd5;
                        Mux1_alu_B = 3'd2;
                        CZen       = 1'b1;
                    end
                    c_OP_NDU: begin
                        Mux2_alu_A = 3'd5;
                        Mux1_alu_B = 3'd2;
                        ALU_op     = 1'b1;
                        CZen       = 1'b1;
                    end
                    c_OP_ADI: begin
                        Mux2_alu_A = 3'd5;
                        Mux1_alu_B = 3'd3;
                        CZen       = 1'b1;
                    end
                    c_OP_LHI: begin
                        Mux2_alu_A = 3'd2;
                        Mux1_alu_B = 3'd0;
                    end
                    default: ;
                endcase
                w_next = S_WB;
            end
            S_WB: begin
                Mux6_RF_dataIn = 1'b1;
                case (opcode)
                    c_OP_ADD, c_OP_NDU: begin
                        Mux4_RF_wadd = 3'd1;
                        Mux3_RF_wen  = 2'd2;
                    end
                    c_OP_ADI: begin
                        Mux4_RF_wadd = 3'd4;
                        Mux3_RF_wen  = 2'd1;
                    end
                    default: begin
                        Mux4_RF_wadd = 3'd0;
                        Mux3_RF_wen  = 2'd1;
                    end
                endcase
                w_next = S_PCINC;
            end
            S_ADDR: begin
                Mux2_alu_A = 3'd3;
                Mux1_alu_B = 3'd2;
                w_next     = S_MEM;
            end
            S_MEM: begin
                case (opcode)
                    c_OP_LW: begin
                        memRead        = 1'b1;
                        Mux6_RF_dataIn = 1'b0;
                        Mux4_RF_wadd   = 3'd0;
                        Mux3_RF_wen    = 2'd1;
                    end
                    c_OP_SW: begin
                        Mux8_memwrite  = 2'd1;
                        Mux9_memDataIn = 1'b0;
                    end
                    default: ;
                endcase
                w_next = S_PCINC;
            end
            S_LMA: begin
                Mux2_alu_A = 3'd6;
                Mux1_alu_B = 3'd4;
                w_next     = S_LMM;
            end
            S_LMM: begin
                case (opcode)
                    c_OP_LM: begin
                        memRead        = 1'b1;
                        Mux6_RF_dataIn = 1'b0;
                        Mux4_RF_wadd   = 3'd2;
                        Mux3_RF_wen    = 2'd3;
                    end
                    c_OP_SM: begin
                        Mux5_RF_read2  = 2'd1;
                        Mux9_memDataIn = 1'b1;
                        Mux8_memwrite  = 2'd2;
                    end
                    default: ;
                endcase
                // All eight register slots are visited; the IR bit-mask gates each write
                w_counter_nxt = r_counter + 3'd1;
                w_next        = (r_counter == 3'd7) ? S_PCINC : S_LMA;
            end
            S_CMP: begin
                Mux2_alu_A = 3'd5;
                Mux1_alu_B = 3'd2;
                ALU_op     = 1'b0;
                w_next     = compare ? S_BR : S_PCINC;
            end
            S_BR: begin
                Mux5_RF_read2 = 2'd2;
                Mux2_alu_A    = (opcode == c_OP_JAL) ? 3'd4 : 3'd3;
                Mux1_alu_B    = 3'd2;
                w_next        = S_PCWR;
            end
            S_LINK: begin
                Mux5_RF_read2 = 2'd2;
                Mux2_alu_A    = 3'd1;
                Mux1_alu_B    = 3'd2;
                w_next        = S_LWR;
            end
            S_LWR: begin
                Mux6_RF_dataIn = 1'b1;
                Mux4_RF_wadd   = 3'd0;
                Mux3_RF_wen    = 2'd1;
                w_next         = (opcode == c_OP_JLR) ? S_JR : S_BR;
            end
            S_JR: begin
                Mux5_RF_read2 = 2'd0;
                Mux2_alu_A    = 3'd0;
                Mux1_alu_B    = 3'd2;
                w_next        = S_PCWR;
            end
            S_PCINC: begin
                Mux5_RF_read2 = 2'd2;
                Mux2_alu_A    = 3'd1;
                Mux1_alu_B    = 3'd2;
                w_next        = S_PCWR;
            end
            S_PCWR: begin
                Mux6_RF_dataIn = 1'b1;
                Mux4_RF_wadd   = 3'd3;
                Mux3_RF_wen    = 2'd1;
                w_next         = S_FETCH0;
            end
            default: w_next = S_FETCH0;
        endcase

        // Suppress every select/enable while reset is held so no write escapes
        if (reset) begin
            Mux1_alu_B     = 3'd0;
            Mux2_alu_A     = 3'd0;
            Mux3_RF_wen    = 2'd0;
            Mux4_RF_wadd   = 3'd0;
            Mux5_RF_read2  = 2'd0;
            Mux6_RF_dataIn = 1'b0;
            Mux8_memwrite  = 2'd0;
            Mux9_memDataIn = 1'b0;
            CZen           = 1'b0;
            ALU_op         = 1'b0;
            memRead        = 1'b0;
            wIR            = 1'b0;
            wtmpA          = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_control_fsm.sv
// ============================================================================
// Module   : tb_control_fsm
// Purpose  : Self-checking bench for control_fsm using an instruction-level
//            reference model of the expected per-cycle control words.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_fsm;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic       compare;
    logic [2:0] Mux1_alu_B;
    logic [2:0] Mux2_alu_A;
    logic [1:0] Mux3_RF_wen;
    logic [2:0] Mux4_RF_wadd;
    logic [1:0] Mux5_RF_read2;
    logic       Mux6_RF_dataIn;
    logic [1:0] Mux8_memwrite;
    logic       Mux9_memDataIn;
    logic       CZen;
    logic       ALU_op;
    logic       memRead;
    logic       wIR;
    logic       wtmpA;
    logic [2:0] counter;
    logic [3:0] state;

    int n_cmp  = 0;
    int n_fail = 0;

    control_fsm #(.RESET_STATE(4'd0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .compare(compare),
        .Mux1_alu_B(Mux1_alu_B), .Mux2_alu_A(Mux2_alu_A),
        .Mux3_RF_wen(Mux3_RF_wen), .Mux4_RF_wadd(Mux4_RF_wadd),
        .Mux5_RF_read2(Mux5_RF_read2), .Mux6_RF_dataIn(Mux6_RF_dataIn),
        .Mux8_memwrite(Mux8_memwrite), .Mux9_memDataIn(Mux9_memDataIn),
        .CZen(CZen), .ALU_op(ALU_op), .memRead(memRead), .wIR(wIR),
        .wtmpA(wtmpA), .counter(counter), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // State numbering of the debug port
    localparam logic [3:0] FETCH0 = 4'd0,  FETCH1 = 4'd1,  DECODE = 4'd2,
                           ALU    = 4'd3,  WB     = 4'd4,  ADDR   = 4'd5,
                           MEM    = 4'd6,  LMA    = 4'd7,  LMM    = 4'd8,
                           CMP    = 4'd9,  BR     = 4'd10, LINK   = 4'd11,
                           LWR    = 4'd12, JR     = 4'd13, PCINC  = 4'd14,
                           PCWR   = 4'd15;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] cnt;
        logic [2:0] b;
        logic [2:0] a;
        logic [1:0] wen;
        logic [2:0] wadd;
        logic [1:0] rd2;
        logic       din;
        logic [1:0] mw;
        logic       mdi;
        logic       cz;
        logic       op;
        logic       mr;
        logic       wir;
        logic       wta;
    } ctl_t;

    function automatic ctl_t mk(input logic [3:0] st, input logic [2:0] cnt,
                                input logic [2:0] b, input logic [2:0] a,
                                input logic [1:0] wen, input logic [2:0] wadd,
                                input logic [1:0] rd2, input logic din,
                                input logic [1:0] mw, input logic mdi,
                                input logic cz, input logic op, input logic mr,
                                input logic wir, input logic wta);
        ctl_t c;
        c = '{st, cnt, b, a, wen, wadd, rd2, din, mw, mdi, cz, op, mr, wir, wta};
        return c;
    endfunction

    function automatic ctl_t observed();
        return mk(state, counter, Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen,
                  Mux4_RF_wadd, Mux5_RF_read2, Mux6_RF_dataIn, Mux8_memwrite,
                  Mux9_memDataIn, CZen, ALU_op, memRead, wIR, wtmpA);
    endfunction

    ctl_t exp_q[$];

    // Instruction-level model: expected control word for every cycle
    task automatic build(input logic [3:0] op, input logic cmp);
        logic taken;
        exp_q.delete();
        exp_q.push_back(mk(FETCH0, 0, 2, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(FETCH1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        exp_q.push_back(mk(DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        taken = 1'b0;
        case (op)
            4'b0000: begin
                exp_q.push_back(mk(ALU, 0, 2, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
                exp_q.push_back(mk(WB,  0, 0, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
            end
            4'b0010: begin
                exp_q.push_back(mk(ALU, 0, 2, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
                exp_q.push_back(mk(WB,  0, 0, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
            end
            4'b0001: begin
                exp_q.push_back(mk(ALU, 0, 3, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
                exp_q.push_back(mk(WB,  0, 0, 0, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0));
            end
            4'b0011: begin
                exp_q.push_back(mk(ALU, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(mk(WB,  0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
            end
            4'b0100: begin
                exp_q.push_back(mk(ADDR, 0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(mk(MEM,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
            end
            4'b0101: begin
                exp_q.push_back(mk(ADDR, 0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(mk(MEM,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
            end
            4'b0110, 4'b0111: begin
                for (int k = 0; k < 8; k++) begin
                    exp_q.push_back(mk(LMA, 3'(k), 4, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                    if (op == 4'b0110)
                        exp_q.push_back(mk(LMM, 3'(k), 0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
                    else
                        exp_q.push_back(mk(LMM, 3'(k), 0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0));
                end
            end
            4'b1100: begin
                exp_q.push_back(mk(CMP, 0, 2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                if (cmp) begin
                    exp_q.push_back(mk(BR, 0, 2, 3, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
                    taken = 1'b1;
                end
            end
            4'b1000, 4'b1001: begin
                exp_q.push_back(mk(LINK, 0, 2, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(mk(LWR,  0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
                if (op == 4'b1000)
                    exp_q.push_back(mk(BR, 0, 2, 4, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
                else
                    exp_q.push_back(mk(JR, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                taken = 1'b1;
            end
            default: ;
        endcase
        if (!taken)
            exp_q.push_back(mk(PCINC, 0, 2, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(PCWR, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic check(input string tag, input int idx, input ctl_t exp);
        ctl_t obs;
        obs = observed();
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, idx, obs, exp);
        end
    endtask

    // Called at a sample point (#1 after a falling edge) with the DUT in FETCH0.
    // abort_at >= 0 asserts reset right after checking that step.
    task automatic run_instr(input string tag, input logic [3:0] op,
                             input logic cmp, input int abort_at);
        opcode  = op;
        compare = cmp;
        build(op, cmp);
        for (int i = 0; i < exp_q.size(); i++) begin
            check(tag, i, exp_q[i]);
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                check({tag, "_in_reset"}, i, '0);
                @(negedge clk);
                #1;
                check({tag, "_held_reset"}, i, '0);
                reset = 1'b0;
                #1;
                return;
            end
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        reset   = 1'b1;
        opcode  = 4'd0;
        compare = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 0, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        run_instr("add",    4'b0000, 1'b0, -1);
        run_instr("lm",     4'b0110, 1'b0, -1);
        run_instr("beq_t",  4'b1100, 1'b1, -1);
        run_instr("beq_nt", 4'b1100, 1'b0, -1);
        run_instr("jal",    4'b1000, 1'b0, -1);
        run_instr("undef",  4'b1111, 1'b0, -1);
        run_instr("jlr",    4'b1001, 1'b1, -1);
        run_instr("sm",     4'b0111, 1'b0, -1);
        run_instr("lw",     4'b0100, 1'b0, -1);
        run_instr("sw",     4'b0101, 1'b1, -1);
        run_instr("adi",    4'b0001, 1'b0, -1);
        run_instr("ndu",    4'b0010, 1'b0, -1);
        run_instr("lhi",    4'b0011, 1'b1, -1);
        // Step 14 of an LM is its LMM cycle with counter == 5
        run_instr("lm_abort", 4'b0110, 1'b0, 14);
        run_instr("after_abort", 4'b0000, 1'b0, -1);

        for (int r = 0; r < 60; r++) begin
            logic [3:0] op_r;
            logic       cmp_r;
            op_r  = 4'($urandom_range(0, 15));
            cmp_r = 1'($urandom_range(0, 1));
            run_instr("rand", op_r, cmp_r, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
